// File: rtl/uart_cmd_master_if.sv
// UART command master link bundle: transmit handshake toward the byte
// transmitter and the byte-valid strobe from the receiver.
//
// Signals:
//   Tx_DV_out   - one-cycle pulse presenting Tx_Byte_out
//   Tx_Byte_out - byte to transmit, held until Tx_Done_in
//   Tx_Done_in  - transmitter byte-complete pulse
//   Rx_DV_in    - receiver byte-valid pulse
//   Rx_Byte_in  - received byte, valid while Rx_DV_in is high
//
// Modports:
//   master - the command initiator (drives Tx_DV_out / Tx_Byte_out)
//   slave  - the transmitter/receiver side
interface uart_cmd_master_if;

    logic       Tx_DV_out;
    logic [7:0] Tx_Byte_out;
    logic       Tx_Done_in;
    logic       Rx_DV_in;
    logic [7:0] Rx_Byte_in;

    modport master (
        output Tx_DV_out,
        output Tx_Byte_out,
        input  Tx_Done_in,
        input  Rx_DV_in,
        input  Rx_Byte_in
    );

    modport slave (
        input  Tx_DV_out,
        input  Tx_Byte_out,
        output Tx_Done_in,
        output Rx_DV_in,
        output Rx_Byte_in
    );

endinterface

// File: rtl/uart_cmd_master.sv
// Host-side UART command initiator: frames (HEADER, A, B, A^B), sends the
// four bytes through the Tx handshake, then waits for one result byte.
//
// Ports:
//   CLK, RST     - clock, synchronous active-high reset
//   Start_in     - issue one command (sampled only while idle)
//   A_in, B_in   - operands, latched when Start_in is accepted
//   Busy_out     - high while a command is in flight
//   Done_out     - one-cycle pulse when a response is captured
//   Result_out   - last captured response byte
//   Timeout_out  - one-cycle pulse when the response wait expires
//   bus          - transmit/receive handshake (uart_cmd_master_if.master)
module uart_cmd_master #(
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter int          CNT_W          = 17
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start_in,
    input  logic [7:0]            A_in,
    input  logic [7:0]            B_in,
    output logic                  Busy_out,
    output logic                  Done_out,
    output logic [7:0]            Result_out,
    output logic                  Timeout_out,
    uart_cmd_master_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_TX,
        WAIT_RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [1:0]       idx;
    logic [1:0]       idx_nx;
    logic [7:0]       op_a;
    logic [7:0]       op_a_nx;
    logic [7:0]       op_b;
    logic [7:0]       op_b_nx;
    logic [7:0]       tx_byte;
    logic [7:0]       tx_byte_nx;
    logic [7:0]       result;
    logic [7:0]       result_nx;
    logic             done;
    logic             done_nx;
    logic             tmo;
    logic             tmo_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;

    // Frame byte selected by the byte index.
    function automatic logic [7:0] frame_byte(
        input logic [1:0] i,
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] r;
        case (i)
            2'd0:    r = HEADER;
            2'd1:    r = a;
            2'd2:    r = b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            idx     <= 2'd0;
            op_a    <= 8'h00;
            op_b    <= 8'h00;
            tx_byte <= 8'h00;
            result  <= 8'h00;
            done    <= 1'b0;
            tmo     <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            op_a    <= op_a_nx;
            op_b    <= op_b_nx;
            tx_byte <= tx_byte_nx;
            result  <= result_nx;
            done    <= done_nx;
            tmo     <= tmo_nx;
            cnt     <= cnt_nx;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        op_a_nx    = op_a;
        op_b_nx    = op_b;
        tx_byte_nx = tx_byte;
        result_nx  = result;
        done_nx    = 1'b0;
        tmo_nx     = 1'b0;
        cnt_nx     = cnt;

        unique case (state)
            IDLE: begin
                if (Start_in) begin
                    op_a_nx    = A_in;
                    op_b_nx    = B_in;
                    idx_nx     = 2'd0;
                    // Byte is loaded on entry so it is valid with DV.
                    tx_byte_nx = HEADER;
                    state_nx   = SEND;
                end
            end

            SEND: begin
                state_nx = WAIT_TX;
            end

            WAIT_TX: begin
                if (bus.Tx_Done_in) begin
                    if (idx != 2'd3) begin
                        idx_nx     = idx + 2'd1;
                        tx_byte_nx = frame_byte(idx + 2'd1, op_a, op_b);
                        state_nx   = SEND;
                    end else begin
                        cnt_nx   = '0;
                        state_nx = WAIT_RESP;
                    end
                end
            end

            WAIT_RESP: begin
                cnt_nx = cnt + CNT_ONE;
                // A response on the expiry cycle takes priority.
                if (bus.Rx_DV_in) begin
                    result_nx = bus.Rx_Byte_in;
                    done_nx   = 1'b1;
                    state_nx  = IDLE;
                end else if (cnt == CNT_LAST) begin
                    tmo_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign Busy_out        = (state != IDLE);
    assign Done_out        = done;
    assign Timeout_out     = tmo;
    assign Result_out      = result;
    assign bus.Tx_DV_out   = (state == SEND);
    assign bus.Tx_Byte_out = tx_byte;

endmodule
